// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A round-robin arbiter picks at most one requester per cycle. The picked
// operation drives the ALU, and the ALU result is captured into that
// requester's response register one clock later.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b     request channel N (valid/ready handshake)
//   respN_valid/ready/result/zero  registered response channel N
//   alu_ctrl/alu_a/alu_b        drive to the shared ALU
//   alu_result/alu_zero         combinational return from the shared ALU
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero,
  input  logic             resp1_ready,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  logic             w_elig0;
  logic             w_elig1;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             r_last;        // 1: requester 1 was granted most recently
  logic             r_resp0_valid;
  logic [WIDTH-1:0] r_resp0_result;
  logic             r_resp0_zero;
  logic             r_resp1_valid;
  logic [WIDTH-1:0] r_resp1_result;
  logic             r_resp1_zero;

  // Eligibility and round-robin grant; a requester is eligible only if its
  // response slot is free or is being drained this same cycle.
  always_comb begin
    w_elig0 = 1'b0;
    w_elig1 = 1'b0;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    if (!rst) begin
      w_elig0 = req0_valid & (~r_resp0_valid | resp0_ready);
      w_elig1 = req1_valid & (~r_resp1_valid | resp1_ready);
      w_gnt0  = w_elig0 & (~w_elig1 | r_last);
      w_gnt1  = w_elig1 & (~w_elig0 | ~r_last);
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // ALU operand mux; idle cycles present a quiet all-zero operation.
  always_comb begin
    alu_ctrl = 3'b000;
    alu_a    = '0;
    alu_b    = '0;
    if (w_gnt0) begin
      alu_ctrl = req0_op;
      alu_a    = req0_a;
      alu_b    = req0_b;
    end else if (w_gnt1) begin
      alu_ctrl = req1_op;
      alu_a    = req1_a;
      alu_b    = req1_b;
    end
  end

  // Last-granted pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end
  end

  // Response slot 0: a new capture takes priority over a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp0_valid  <= 1'b0;
      r_resp0_result <= '0;
      r_resp0_zero   <= 1'b0;
    end else if (w_gnt0) begin
      r_resp0_valid  <= 1'b1;
      r_resp0_result <= alu_result;
      r_resp0_zero   <= alu_zero;
    end else if (resp0_ready) begin
      r_resp0_valid  <= 1'b0;
    end
  end

  // Response slot 1: same policy as slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp1_valid  <= 1'b0;
      r_resp1_result <= '0;
      r_resp1_zero   <= 1'b0;
    end else if (w_gnt1) begin
      r_resp1_valid  <= 1'b1;
      r_resp1_result <= alu_result;
      r_resp1_zero   <= alu_zero;
    end else if (resp1_ready) begin
      r_resp1_valid  <= 1'b0;
    end
  end

  assign resp0_valid  = r_resp0_valid;
  assign resp0_result = r_resp0_result;
  assign resp0_zero   = r_resp0_zero;
  assign resp1_valid  = r_resp1_valid;
  assign resp1_result = r_resp1_result;
  assign resp1_zero   = r_resp1_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table, multi-cycle reset sequence and a
// randomized run checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;

  localparam int unsigned W = 32;
  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SLT = 3'b101;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic [W-1:0] resp0_result, resp1_result;
  logic         resp0_ready, resp1_ready;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_zero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result),
    .resp0_zero(resp0_zero), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result),
    .resp1_zero(resp1_zero), .resp1_ready(resp1_ready),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Shared ALU behaviour; unused codes return a^b.
  function automatic logic [W-1:0] ref_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      SLT:     return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v0, input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input bit v1, input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input bit rr0, input bit rr1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    resp0_ready = rr0; resp1_ready = rr1;
  endtask

  // Enters and leaves at 1 time unit after a rising edge.
  task automatic do_reset();
    drive(1, ADD, 1, 1, 1, ADD, 2, 2, 1, 1);
    rst = 1'b1;
    #1;
    chk("rst_resp0_valid", W'(resp0_valid), W'(0));
    chk("rst_resp1_valid", W'(resp1_valid), W'(0));
    chk("rst_req0_ready", W'(req0_ready), W'(0));
    chk("rst_req1_ready", W'(req1_ready), W'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp0_result", resp0_result, W'(0));
    chk("rst_resp1_zero", W'(resp1_zero), W'(0));
    rst = 1'b0;
  endtask

  typedef struct {
    bit           rb;
    bit           v0;  logic [2:0] op0; logic [W-1:0] a0; logic [W-1:0] b0;
    bit           v1;  logic [2:0] op1; logic [W-1:0] a1; logic [W-1:0] b1;
    bit           rr0; bit rr1;
    bit           er0; bit er1;
    bit           ev0; logic [W-1:0] eres0; bit ez0;
    bit           ev1; logic [W-1:0] eres1; bit ez1;
  } vec_t;

  function automatic vec_t mk(bit rb,
      bit v0, logic [2:0] op0, logic [W-1:0] a0, logic [W-1:0] b0,
      bit v1, logic [2:0] op1, logic [W-1:0] a1, logic [W-1:0] b1,
      bit rr0, bit rr1, bit er0, bit er1,
      bit ev0, logic [W-1:0] eres0, bit ez0,
      bit ev1, logic [W-1:0] eres1, bit ez1);
    vec_t v;
    v.rb = rb; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1; v.er0 = er0; v.er1 = er1;
    v.ev0 = ev0; v.eres0 = eres0; v.ez0 = ez0;
    v.ev1 = ev1; v.eres1 = eres1; v.ez1 = ez1;
    return v;
  endfunction

  // Transaction-level model state.
  int           m_last;
  bit           m_v[2];
  logic [W-1:0] m_r[2];
  bit           m_z[2];

  initial begin
    vec_t tbl[18];
    int   gw;
    bit   e[2];
    bit   rr[2];
    logic [2:0]   op[2];
    logic [W-1:0] a[2];
    logic [W-1:0] b[2];

    // single add, idle, tie sequence, slt, backpressure, back-to-back
    tbl[0]  = mk(0, 1,ADD,5,7,          0,ADD,0,0,       1,1, 1,0, 1,12,0,           0,0,0);
    tbl[1]  = mk(0, 0,ADD,0,0,          0,ADD,0,0,       1,1, 0,0, 0,0,0,            0,0,0);
    tbl[2]  = mk(1, 1,SUB,9,9,          1,OR,32'h0F,32'hF0, 1,1, 1,0, 1,0,1,         0,0,0);
    tbl[3]  = mk(0, 1,SUB,9,9,          1,OR,32'h0F,32'hF0, 1,1, 0,1, 0,0,0,         1,32'hFF,0);
    tbl[4]  = mk(0, 1,SUB,9,9,          1,OR,32'h0F,32'hF0, 1,1, 1,0, 1,0,1,         0,0,0);
    tbl[5]  = mk(0, 1,SUB,9,9,          1,OR,32'h0F,32'hF0, 1,1, 0,1, 0,0,0,         1,32'hFF,0);
    tbl[6]  = mk(0, 1,SLT,3,8,          0,ADD,0,0,       1,1, 1,0, 1,1,0,            0,0,0);
    tbl[7]  = mk(0, 1,SLT,8,3,          0,ADD,0,0,       1,1, 1,0, 1,0,1,            0,0,0);
    tbl[8]  = mk(0, 1,AND,32'hF0F0,32'h0FF0, 1,SUB,3,5, 1,1, 0,1, 0,0,0,         1,32'hFFFFFFFE,0);
    tbl[9]  = mk(0, 1,AND,32'hF0F0,32'h0FF0, 1,SUB,3,5, 1,1, 1,0, 1,32'h00F0,0,  0,0,0);
    tbl[10] = mk(0, 1,ADD,1,1,          1,ADD,2,2,       0,1, 0,1, 1,32'h00F0,0,     1,4,0);
    tbl[11] = mk(0, 1,ADD,1,1,          1,ADD,3,3,       0,1, 0,1, 1,32'h00F0,0,     1,6,0);
    tbl[12] = mk(0, 1,ADD,1,1,          1,ADD,4,4,       1,1, 1,0, 1,2,0,            0,0,0);
    for (int k = 0; k < 4; k++)
      tbl[13+k] = mk(0, 1,ADD,W'(k+1),10, 0,ADD,0,0,   1,1, 1,0, 1,W'(k+11),0,     0,0,0);
    tbl[17] = mk(0, 0,ADD,0,0,          0,ADD,0,0,       1,1, 0,0, 0,0,0,            0,0,0);

    drive(0, ADD, 0, 0, 0, ADD, 0, 0, 0, 0);
    #1;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rb) do_reset();
      drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
            tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].rr0, tbl[i].rr1);
      @(negedge clk);
      chk($sformatf("v%0d_req0_ready", i), W'(req0_ready), W'(tbl[i].er0));
      chk($sformatf("v%0d_req1_ready", i), W'(req1_ready), W'(tbl[i].er1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_resp0_valid", i), W'(resp0_valid), W'(tbl[i].ev0));
      chk($sformatf("v%0d_resp1_valid", i), W'(resp1_valid), W'(tbl[i].ev1));
      if (tbl[i].ev0) begin
        chk($sformatf("v%0d_resp0_result", i), resp0_result, tbl[i].eres0);
        chk($sformatf("v%0d_resp0_zero", i), W'(resp0_zero), W'(tbl[i].ez0));
      end
      if (tbl[i].ev1) begin
        chk($sformatf("v%0d_resp1_result", i), resp1_result, tbl[i].eres1);
        chk($sformatf("v%0d_resp1_zero", i), W'(resp1_zero), W'(tbl[i].ez1));
      end
    end

    // Reset mid-stream with a held response on requester 1.
    drive(0, ADD, 0, 0, 1, ADD, 5, 5, 1, 0);
    @(posedge clk);
    #1;
    chk("mid_resp1_valid_before", W'(resp1_valid), W'(1));
    chk("mid_resp1_result_before", resp1_result, W'(10));
    drive(1, ADD, 1, 1, 1, ADD, 5, 5, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_resp1_valid_async", W'(resp1_valid), W'(0));
    chk("mid_resp1_result_async", resp1_result, W'(0));
    chk("mid_req0_ready_in_rst", W'(req0_ready), W'(0));
    chk("mid_req1_ready_in_rst", W'(req1_ready), W'(0));
    @(posedge clk);
    #1;
    drive(0, ADD, 0, 0, 0, ADD, 0, 0, 1, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_resp0_valid", W'(resp0_valid), W'(0));
    chk("post_rst_resp1_valid", W'(resp1_valid), W'(0));
    drive(1, ADD, 1, 2, 1, ADD, 3, 4, 1, 1);
    @(negedge clk);
    chk("post_rst_tie_req0_ready", W'(req0_ready), W'(1));
    chk("post_rst_tie_req1_ready", W'(req1_ready), W'(0));
    @(posedge clk);
    #1;
    chk("post_rst_tie_resp0_result", resp0_result, W'(3));
    chk("post_rst_tie_resp1_valid", W'(resp1_valid), W'(0));

    // Randomized run against the transaction-level model.
    do_reset();
    m_last = 1;
    m_v = '{0, 0};
    m_r = '{0, 0};
    m_z = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 5))
          0: op[i] = ADD;
          1: op[i] = SUB;
          2: op[i] = AND;
          3: op[i] = OR;
          4: op[i] = SLT;
          default: op[i] = 3'($urandom_range(0, 7));
        endcase
        a[i]  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 7));
        b[i]  = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 7));
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      drive($urandom_range(0, 2) != 0, op[0], a[0], b[0],
            $urandom_range(0, 2) != 0, op[1], a[1], b[1], rr[0], rr[1]);
      e[0] = req0_valid && (!m_v[0] || rr[0]);
      e[1] = req1_valid && (!m_v[1] || rr[1]);
      if (e[0] && e[1]) gw = (m_last == 0) ? 1 : 0;
      else if (e[0])    gw = 0;
      else if (e[1])    gw = 1;
      else              gw = -1;
      @(negedge clk);
      chk("rnd_req0_ready", W'(req0_ready), W'(gw == 0));
      chk("rnd_req1_ready", W'(req1_ready), W'(gw == 1));
      chk("rnd_alu_ctrl", W'(alu_ctrl), (gw < 0) ? W'(0) : W'(op[gw]));
      chk("rnd_alu_a", alu_a, (gw < 0) ? W'(0) : a[gw]);
      chk("rnd_alu_b", alu_b, (gw < 0) ? W'(0) : b[gw]);
      chk("rnd_resp0_valid", W'(resp0_valid), W'(m_v[0]));
      chk("rnd_resp1_valid", W'(resp1_valid), W'(m_v[1]));
      if (m_v[0]) begin
        chk("rnd_resp0_result", resp0_result, m_r[0]);
        chk("rnd_resp0_zero", W'(resp0_zero), W'(m_z[0]));
      end
      if (m_v[1]) begin
        chk("rnd_resp1_result", resp1_result, m_r[1]);
        chk("rnd_resp1_zero", W'(resp1_zero), W'(m_z[1]));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (gw == i) begin
          m_v[i] = 1;
          m_r[i] = ref_alu(op[i], a[i], b[i]);
          m_z[i] = (m_r[i] == '0);
        end else if (rr[i]) begin
          m_v[i] = 0;
        end
      end
      if (gw >= 0) m_last = gw;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester i has an operation.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  operation of requester i accepted this cycle.
REQ-006 SHALL have ports: req0_op / req1_op  input  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-007 SHALL have ports: req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 SHALL have ports: resp0_valid / resp1_valid  output  1  response register i holds a result.
REQ-009 SHALL have ports: resp0_result / resp1_result  output  WIDTH  registered ALU result.
REQ-010 SHALL have ports: resp0_zero / resp1_zero  output  1  registered ALU zero flag.
REQ-011 SHALL have ports: resp0_ready / resp1_ready  input  1  consumer i takes the response.
REQ-012 SHALL have ports: alu_ctrl  output  3; alu_a, alu_b  output  WIDTH  drive to the shared ALU.
REQ-013 SHALL have ports: alu_result  input  WIDTH; alu_zero  input  1  from the shared ALU (combinational).

Function
REQ-014 SHALL share one combinational ALU between two requesters; at most one operation issued per cycle.
REQ-015 SHALL treat requester i as eligible when req_i_valid=1 and (resp_i_valid=0 or resp_i_ready=1).
REQ-016 SHALL grant the single eligible requester; if both eligible, SHALL grant the one not granted most recently (round-robin).
REQ-017 SHALL update the last-granted pointer only on an accepted transfer (valid and ready both 1).
REQ-018 SHALL assert req_i_ready only for the granted requester; never both in one cycle.
REQ-019 SHALL drive alu_ctrl/alu_a/alu_b from the granted requester's op/a/b in the grant cycle; with no grant, SHALL drive 000/0/0.
REQ-020 SHALL capture alu_result and alu_zero into response register i at the clock edge ending the accept cycle; resp_i_valid=1 from the next cycle (latency exactly 1).
REQ-021 SHALL hold resp_i_result/resp_i_zero stable while resp_i_valid=1 and resp_i_ready=0.
REQ-022 SHALL clear resp_i_valid on resp_i_ready=1 unless a new result for i is captured the same edge, in which case the new result replaces it and valid stays 1 (full throughput per requester).
REQ-023 SHALL pass op codes unfiltered; unused codes produce whatever the ALU returns.
REQ-024 req_i_ready MAY depend combinationally on req_0_valid, req_1_valid, resp_i_valid, resp_i_ready; requesters SHALL NOT make valid depend on ready.
REQ-025 SHALL not lose, duplicate or reorder responses per requester.

Reset
REQ-026 On rst=1, immediately and asynchronously: resp0_valid=resp1_valid=0, resp results=0, zero flags=0, pointer set so requester 0 wins the first tie.
REQ-027 Reset asserted mid-operation SHALL discard any held or in-flight result; no response appears after release for pre-reset requests.
REQ-028 req_i_ready SHALL be 0 while rst=1.

Verification
REQ-029 Single: req0 add a=5, b=7 accepted cycle N -> resp0_valid=1 at N+1, result=12, zero=0; resp1_valid stays 0.
REQ-030 Tie: both valid from reset, req0 sub 9-9, req1 or 0x0F|0xF0 -> req0 granted first (result 0, zero=1), req1 next cycle (result 0xFF); sustained ties alternate 0,1,0,1.
REQ-031 Backpressure: resp0_ready=0 with resp0_valid=1 -> req0_ready=0, resp0 value held stable; req1 keeps being served each cycle.
REQ-032 Back-to-back: req0 valid 4 consecutive cycles, resp0_ready=1, req1 idle -> 4 accepts, 4 consecutive responses in order, no bubbles.
REQ-033 slt: a=3, b=8 -> result=1; a=8, b=3 -> result=0, zero=1.
REQ-034 Reset mid-stream: rst pulsed while resp1_valid=1 -> resp1_valid=0 immediately, no response after release; first post-reset tie grants req0.
